// File: rtl/rf_wport_arbiter_if.sv
// Bundles the pipeline writeback, divider result and register-file write signals
// shared by the write-port arbiter and whatever drives or observes it.
interface rf_wport_arbiter_if;
   logic        wb_reg_write_i;
   logic [4:0]  wb_rd_addr_i;
   logic [31:0] wb_data_i;
   logic        div_valid_i;
   logic [4:0]  div_rd_addr_i;
   logic [31:0] div_data_i;
   logic        div_ready_o;
   logic        pipe_hold_o;
   logic        rf_wen_o;
   logic [4:0]  rf_rd_addr_o;
   logic [31:0] rf_data_o;
   logic [31:0] busy_o;

   // Divider handshake: a result transfers on a rising edge where div_valid_i and
   // div_ready_o are both high; the divider holds addr/data stable while waiting.
   modport slave (
      input  wb_reg_write_i, wb_rd_addr_i, wb_data_i,
      input  div_valid_i, div_rd_addr_i, div_data_i,
      output div_ready_o, pipe_hold_o,
      output rf_wen_o, rf_rd_addr_o, rf_data_o, busy_o
   );

   modport master (
      output wb_reg_write_i, wb_rd_addr_i, wb_data_i,
      output div_valid_i, div_rd_addr_i, div_data_i,
      input  div_ready_o, pipe_hold_o,
      input  rf_wen_o, rf_rd_addr_o, rf_data_o, busy_o
   );
endinterface

// File: rtl/rf_wport_arbiter.sv
// Shares the single register-file write port between in-order pipeline writeback
// and buffered divider results, with a starvation-forced pipeline hold.
module rf_wport_arbiter #(
   parameter int DEPTH      = 2,
   parameter int STARVE_MAX = 4
) (
   input logic               clk,
   input logic               rst_n,
   rf_wport_arbiter_if.slave bus
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int SW = $clog2(STARVE_MAX + 1);

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_PIPE = 2'd1,
      GNT_FIFO = 2'd2
   } grant_e;

   logic [4:0]    r_mem_addr [DEPTH];
   logic [31:0]   r_mem_data [DEPTH];
   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic [CW-1:0] r_count;
   logic [SW-1:0] r_starve;
   logic          r_hold;
   logic          r_rf_wen;
   logic [4:0]    r_rf_addr;
   logic [31:0]   r_rf_data;

   logic          w_fifo_ne;
   logic          w_div_ready;
   logic          w_push;
   logic          w_pop;
   logic          w_pipe_req;
   grant_e        w_grant;
   logic [SW-1:0] w_starve_inc;
   logic [SW-1:0] w_starve_nxt;
   logic          w_hold_nxt;
   logic [31:0]   w_busy;

   assign w_fifo_ne   = (r_count != '0);
   assign w_div_ready = rst_n && (r_count < CW'(DEPTH));
   // x0 results complete the handshake but are never stored.
   assign w_push      = bus.div_valid_i && w_div_ready && (bus.div_rd_addr_i != 5'd0);
   assign w_pipe_req  = bus.wb_reg_write_i && (bus.wb_rd_addr_i != 5'd0);
   assign w_pop       = (w_grant == GNT_FIFO);

   // A hold cycle belongs to the FIFO; the pipeline request is ignored and re-presented.
   always_comb begin
      w_grant = GNT_NONE;
      if (r_hold && w_fifo_ne) begin
         w_grant = GNT_FIFO;
      end else if (w_pipe_req && !r_hold) begin
         w_grant = GNT_PIPE;
      end else if (w_fifo_ne) begin
         w_grant = GNT_FIFO;
      end
   end

   always_comb begin
      w_starve_inc = r_starve + 1'b1;
      w_starve_nxt = r_starve;
      w_hold_nxt   = 1'b0;
      if (w_pop || !w_fifo_ne) begin
         w_starve_nxt = '0;
      end else if (w_grant == GNT_PIPE) begin
         if (w_starve_inc == SW'(STARVE_MAX)) begin
            w_hold_nxt   = 1'b1;
            w_starve_nxt = '0;
         end else begin
            w_starve_nxt = w_starve_inc;
         end
      end
   end

   // Entry i is live when its distance from the read pointer is below the count.
   always_comb begin
      logic [PW-1:0] w_off;
      w_busy = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_off = PW'(i) - r_rptr;
         if ({1'b0, w_off} < r_count) begin
            w_busy[r_mem_addr[i]] = 1'b1;
         end
      end
      w_busy[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_addr[r_wptr] <= bus.div_rd_addr_i;
         r_mem_data[r_wptr] <= bus.div_data_i;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wptr   <= '0;
         r_rptr   <= '0;
         r_count  <= '0;
         r_starve <= '0;
         r_hold   <= 1'b0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         r_starve <= w_starve_nxt;
         r_hold   <= w_hold_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rf_wen  <= 1'b0;
         r_rf_addr <= '0;
         r_rf_data <= '0;
      end else begin
         case (w_grant)
            GNT_PIPE: begin
               r_rf_wen  <= 1'b1;
               r_rf_addr <= bus.wb_rd_addr_i;
               r_rf_data <= bus.wb_data_i;
            end
            GNT_FIFO: begin
               r_rf_wen  <= 1'b1;
               r_rf_addr <= r_mem_addr[r_rptr];
               r_rf_data <= r_mem_data[r_rptr];
            end
            default: begin
               r_rf_wen  <= 1'b0;
               r_rf_addr <= '0;
               r_rf_data <= '0;
            end
         endcase
      end
   end

   assign bus.div_ready_o  = w_div_ready;
   assign bus.pipe_hold_o  = r_hold;
   assign bus.rf_wen_o     = r_rf_wen;
   assign bus.rf_rd_addr_o = r_rf_addr;
   assign bus.rf_data_o    = r_rf_data;
   assign bus.busy_o       = w_busy;

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Directed scenarios plus a randomized run against a queue-level model of the
// write-port arbiter.
module tb_rf_wport_arbiter;
   localparam int DEPTH      = 2;
   localparam int STARVE_MAX = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   rf_wport_arbiter_if bus ();

   rf_wport_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_pass  = 0;
   int n_total = 0;

   // model state: pending divider results as {addr, data}
   logic [36:0] m_q[$];
   int          m_starve;
   logic        m_hold;
   logic        m_wen;
   logic [4:0]  m_addr;
   logic [31:0] m_data;

   logic [36:0] exp_q[$];
   logic [36:0] got_q[$];

   task automatic drive_wb(input logic we, input logic [4:0] rd, input logic [31:0] d);
      bus.wb_reg_write_i = we;
      bus.wb_rd_addr_i   = rd;
      bus.wb_data_i      = d;
   endtask

   task automatic drive_div(input logic v, input logic [4:0] rd, input logic [31:0] d);
      bus.div_valid_i   = v;
      bus.div_rd_addr_i = rd;
      bus.div_data_i    = d;
   endtask

   task automatic idle();
      drive_wb(1'b0, 5'd0, 32'd0);
      drive_div(1'b0, 5'd0, 32'd0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] model_busy();
      logic [31:0] b;
      b = '0;
      foreach (m_q[i]) b[m_q[i][36:32]] = 1'b1;
      b[0] = 1'b0;
      return b;
   endfunction

   // One clock edge of the arbiter, described by its rules rather than its registers.
   task automatic model_step(input logic rst, input logic we, input logic [4:0] wrd,
                             input logic [31:0] wd, input logic dv, input logic [4:0] drd,
                             input logic [31:0] dd);
      logic        ne, rdy, pipe, hold_n;
      logic [36:0] head;
      int          src;
      if (!rst) begin
         m_q.delete();
         m_starve = 0;
         m_hold   = 1'b0;
         m_wen    = 1'b0;
         m_addr   = '0;
         m_data   = '0;
         return;
      end
      ne     = (m_q.size() > 0);
      rdy    = (m_q.size() < DEPTH);
      pipe   = we && (wrd != 5'd0);
      hold_n = 1'b0;
      if (m_hold && ne) src = 2;
      else if (pipe && !m_hold) src = 1;
      else if (ne) src = 2;
      else src = 0;
      if (src == 2 || !ne) begin
         m_starve = 0;
      end else if (src == 1) begin
         m_starve++;
         if (m_starve == STARVE_MAX) begin
            hold_n   = 1'b1;
            m_starve = 0;
         end
      end
      m_wen = (src != 0);
      if (src == 1) begin
         m_addr = wrd;
         m_data = wd;
      end else if (src == 2) begin
         head   = m_q.pop_front();
         m_addr = head[36:32];
         m_data = head[31:0];
      end
      if (dv && rdy && drd != 5'd0) m_q.push_back({drd, dd});
      m_hold = hold_n;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive_wb(1'b1, 5'd5, 32'h1234);
      drive_div(1'b1, 5'd7, 32'h5678);
      for (int i = 0; i < 3; i++) begin
         tick();
         n_total++; if (bus.rf_wen_o !== 1'b0) $display("FAIL reset_wen: got %0h want 0", bus.rf_wen_o); else n_pass++;
         n_total++; if (bus.rf_rd_addr_o !== 5'd0) $display("FAIL reset_addr: got %0h want 0", bus.rf_rd_addr_o); else n_pass++;
         n_total++; if (bus.rf_data_o !== 32'd0) $display("FAIL reset_data: got %0h want 0", bus.rf_data_o); else n_pass++;
         n_total++; if (bus.pipe_hold_o !== 1'b0) $display("FAIL reset_hold: got %0h want 0", bus.pipe_hold_o); else n_pass++;
         n_total++; if (bus.busy_o !== 32'd0) $display("FAIL reset_busy: got %0h want 0", bus.busy_o); else n_pass++;
         n_total++; if (bus.div_ready_o !== 1'b0) $display("FAIL reset_ready: got %0h want 0", bus.div_ready_o); else n_pass++;
      end
      idle();
      rst_n = 1'b1;
      #1;
      n_total++; if (bus.div_ready_o !== 1'b1) $display("FAIL release_ready: got %0h want 1", bus.div_ready_o); else n_pass++;
      tick();
   endtask

   task automatic test_pipeline_only();
      drive_wb(1'b1, 5'd5, 32'h11);
      tick();
      idle();
      n_total++; if (bus.rf_wen_o !== 1'b1) $display("FAIL pipe_wen: got %0h want 1", bus.rf_wen_o); else n_pass++;
      n_total++; if (bus.rf_rd_addr_o !== 5'd5) $display("FAIL pipe_addr: got %0h want 5", bus.rf_rd_addr_o); else n_pass++;
      n_total++; if (bus.rf_data_o !== 32'h11) $display("FAIL pipe_data: got %0h want 11", bus.rf_data_o); else n_pass++;
      n_total++; if (bus.busy_o !== 32'd0) $display("FAIL pipe_busy: got %0h want 0", bus.busy_o); else n_pass++;
      tick();
      n_total++; if (bus.rf_wen_o !== 1'b0) $display("FAIL pipe_wen_after: got %0h want 0", bus.rf_wen_o); else n_pass++;
   endtask

   task automatic test_divider_idle();
      drive_div(1'b1, 5'd7, 32'hDEAD);
      #1;
      n_total++; if (bus.div_ready_o !== 1'b1) $display("FAIL div_ready: got %0h want 1", bus.div_ready_o); else n_pass++;
      tick();
      idle();
      n_total++; if (bus.busy_o !== 32'h80) $display("FAIL div_busy_set: got %0h want 80", bus.busy_o); else n_pass++;
      n_total++; if (bus.rf_wen_o !== 1'b0) $display("FAIL div_wen_early: got %0h want 0", bus.rf_wen_o); else n_pass++;
      tick();
      n_total++; if (bus.rf_wen_o !== 1'b1) $display("FAIL div_wen: got %0h want 1", bus.rf_wen_o); else n_pass++;
      n_total++; if (bus.rf_rd_addr_o !== 5'd7) $display("FAIL div_addr: got %0h want 7", bus.rf_rd_addr_o); else n_pass++;
      n_total++; if (bus.rf_data_o !== 32'hDEAD) $display("FAIL div_data: got %0h want dead", bus.rf_data_o); else n_pass++;
      n_total++; if (bus.busy_o !== 32'd0) $display("FAIL div_busy_clear: got %0h want 0", bus.busy_o); else n_pass++;
      tick();
      n_total++; if (bus.rf_wen_o !== 1'b0) $display("FAIL div_wen_after: got %0h want 0", bus.rf_wen_o); else n_pass++;
   endtask

   task automatic test_starvation();
      drive_wb(1'b1, 5'd10, 32'h100);
      drive_div(1'b1, 5'd3, 32'h333);
      tick();
      drive_div(1'b0, 5'd0, 32'd0);
      n_total++; if (bus.rf_rd_addr_o !== 5'd10) $display("FAIL starve_first_addr: got %0h want a", bus.rf_rd_addr_o); else n_pass++;
      n_total++; if (bus.busy_o !== 32'h8) $display("FAIL starve_busy: got %0h want 8", bus.busy_o); else n_pass++;
      for (int i = 0; i < 4; i++) begin
         drive_wb(1'b1, 5'(11 + i), 32'h101 + 32'(i));
         tick();
         n_total++; if (bus.rf_wen_o !== 1'b1 || bus.rf_rd_addr_o !== 5'(11 + i) || bus.rf_data_o !== 32'h101 + 32'(i))
            $display("FAIL starve_pipe_write: got %0h/%0h want %0h/%0h", bus.rf_rd_addr_o, bus.rf_data_o, 11 + i, 32'h101 + 32'(i)); else n_pass++;
         n_total++; if (bus.pipe_hold_o !== (i == 3)) $display("FAIL starve_hold: got %0h want %0h at step %0d", bus.pipe_hold_o, (i == 3), i); else n_pass++;
      end
      drive_wb(1'b1, 5'd15, 32'h105);
      tick();
      n_total++; if (bus.rf_wen_o !== 1'b1 || bus.rf_rd_addr_o !== 5'd3 || bus.rf_data_o !== 32'h333)
         $display("FAIL starve_fifo_write: got %0h/%0h want 3/333", bus.rf_rd_addr_o, bus.rf_data_o); else n_pass++;
      n_total++; if (bus.pipe_hold_o !== 1'b0) $display("FAIL starve_hold_once: got %0h want 0", bus.pipe_hold_o); else n_pass++;
      n_total++; if (bus.busy_o !== 32'd0) $display("FAIL starve_busy_clear: got %0h want 0", bus.busy_o); else n_pass++;
      tick();
      idle();
      n_total++; if (bus.rf_wen_o !== 1'b1 || bus.rf_rd_addr_o !== 5'd15 || bus.rf_data_o !== 32'h105)
         $display("FAIL starve_represent: got %0h/%0h want f/105", bus.rf_rd_addr_o, bus.rf_data_o); else n_pass++;
      tick();
   endtask

   task automatic test_fifo_full();
      logic exp_ready;
      exp_q.delete();
      got_q.delete();
      exp_q.push_back({5'd4, 32'hA4});
      exp_q.push_back({5'd6, 32'hB6});
      exp_q.push_back({5'd8, 32'hC8});
      for (int c = 0; c < 12; c++) begin
         drive_wb(c <= 6, 5'd20, 32'h2000 + 32'(c));
         if (c == 0) drive_div(1'b1, 5'd4, 32'hA4);
         else if (c == 1) drive_div(1'b1, 5'd6, 32'hB6);
         else if (c <= 6) drive_div(1'b1, 5'd8, 32'hC8);
         else drive_div(1'b0, 5'd0, 32'd0);
         #1;
         exp_ready = (c < 2) || (c == 6) || (c >= 8);
         n_total++; if (bus.div_ready_o !== exp_ready) $display("FAIL full_ready: got %0h want %0h at cycle %0d", bus.div_ready_o, exp_ready, c); else n_pass++;
         n_total++; if (bus.pipe_hold_o !== (c == 5)) $display("FAIL full_hold: got %0h want %0h at cycle %0d", bus.pipe_hold_o, (c == 5), c); else n_pass++;
         tick();
         if (bus.rf_wen_o === 1'b1 && bus.rf_rd_addr_o != 5'd20) got_q.push_back({bus.rf_rd_addr_o, bus.rf_data_o});
      end
      idle();
      n_total++; if (got_q.size() != exp_q.size()) $display("FAIL full_count: got %0d want %0d", got_q.size(), exp_q.size()); else n_pass++;
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_total++; if (got_q[i] !== exp_q[i]) $display("FAIL full_order: got %0h want %0h at %0d", got_q[i], exp_q[i], i); else n_pass++;
      end
   endtask

   task automatic test_x0();
      drive_wb(1'b1, 5'd0, 32'hAAAA);
      drive_div(1'b1, 5'd0, 32'hBBBB);
      #1;
      n_total++; if (bus.div_ready_o !== 1'b1) $display("FAIL x0_ready: got %0h want 1", bus.div_ready_o); else n_pass++;
      tick();
      idle();
      n_total++; if (bus.rf_wen_o !== 1'b0) $display("FAIL x0_wen: got %0h want 0", bus.rf_wen_o); else n_pass++;
      n_total++; if (bus.busy_o !== 32'd0) $display("FAIL x0_busy: got %0h want 0", bus.busy_o); else n_pass++;
      tick();
      n_total++; if (bus.rf_wen_o !== 1'b0) $display("FAIL x0_wen_late: got %0h want 0", bus.rf_wen_o); else n_pass++;
      drive_wb(1'b1, 5'd12, 32'h12);
      drive_div(1'b1, 5'd9, 32'h99);
      tick();
      drive_wb(1'b1, 5'd0, 32'h0);
      drive_div(1'b0, 5'd0, 32'd0);
      n_total++; if (bus.rf_rd_addr_o !== 5'd12 || bus.rf_data_o !== 32'h12) $display("FAIL x0_pipe: got %0h/%0h want c/12", bus.rf_rd_addr_o, bus.rf_data_o); else n_pass++;
      n_total++; if (bus.busy_o !== 32'h200) $display("FAIL x0_busy9: got %0h want 200", bus.busy_o); else n_pass++;
      tick();
      idle();
      n_total++; if (bus.rf_wen_o !== 1'b1 || bus.rf_rd_addr_o !== 5'd9 || bus.rf_data_o !== 32'h99)
         $display("FAIL x0_idle_grant: got %0h/%0h/%0h want 1/9/99", bus.rf_wen_o, bus.rf_rd_addr_o, bus.rf_data_o); else n_pass++;
      tick();
   endtask

   task automatic test_random();
      logic        we, dv, rst, pend, exp_ready;
      logic [4:0]  wrd, drd;
      logic [31:0] wd, dd;
      pend = 1'b0;
      dv = 1'b0; drd = '0; dd = '0;
      rst_n = 1'b0;
      idle();
      tick();
      model_step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      for (int c = 0; c < 600; c++) begin
         n_total++; if (bus.rf_wen_o !== m_wen) $display("FAIL rnd_wen: got %0h want %0h at %0d", bus.rf_wen_o, m_wen, c); else n_pass++;
         if (m_wen) begin
            n_total++; if (bus.rf_rd_addr_o !== m_addr || bus.rf_data_o !== m_data)
               $display("FAIL rnd_write: got %0h/%0h want %0h/%0h at %0d", bus.rf_rd_addr_o, bus.rf_data_o, m_addr, m_data, c); else n_pass++;
         end
         n_total++; if (bus.pipe_hold_o !== m_hold) $display("FAIL rnd_hold: got %0h want %0h at %0d", bus.pipe_hold_o, m_hold, c); else n_pass++;
         n_total++; if (bus.busy_o !== model_busy()) $display("FAIL rnd_busy: got %0h want %0h at %0d", bus.busy_o, model_busy(), c); else n_pass++;
         rst = ($urandom_range(0, 99) != 0);
         we  = ($urandom_range(0, 3) != 0);
         wrd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         wd  = $urandom;
         if (!pend) begin
            dv  = ($urandom_range(0, 2) == 0);
            drd = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            dd  = $urandom;
         end
         rst_n = rst;
         drive_wb(we, wrd, wd);
         drive_div(dv, drd, dd);
         #1;
         exp_ready = rst && (m_q.size() < DEPTH);
         n_total++; if (bus.div_ready_o !== exp_ready) $display("FAIL rnd_ready: got %0h want %0h at %0d", bus.div_ready_o, exp_ready, c); else n_pass++;
         pend = dv && !exp_ready;
         model_step(rst, we, wrd, wd, dv, drd, dd);
         tick();
      end
      rst_n = 1'b1;
      idle();
   endtask

   initial begin
      idle();
      test_reset();
      test_pipeline_only();
      test_divider_idle();
      test_starvation();
      test_fifo_full();
      test_x0();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/rf_wport_arbiter.md
# rf_wport_arbiter

- Shares the register file's single write port between the in-order pipeline writeback (MEM/WB) and the out-of-order, long-latency M-extension divider result path.
- Buffers divider results in a small FIFO and grants the port to the pipeline by default.
- Forces a one-cycle pipeline hold when buffered results have waited too long.
- Publishes a busy mask of buffered destinations so the hazard unit can stall readers.
- Sits between the WB stage, the divider, and the `wb_*` write inputs of the decode stage.

## Interface
Parameters:
- DEPTH, 2, divider result FIFO entries (power of two, ≥2)
- STARVE_MAX, 4, consecutive pipeline grants with FIFO non-empty before a hold is forced (≥1)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- wb_reg_write_i  in  1  pipeline writeback request
- wb_rd_addr_i  in  5  pipeline destination register
- wb_data_i  in  32  pipeline writeback data
- div_valid_i  in  1  divider result valid
- div_rd_addr_i  in  5  divider destination register
- div_data_i  in  32  divider result
- div_ready_o  out  1  FIFO can accept a result this cycle
- pipe_hold_o  out  1  pipeline must freeze; the WB request presented this cycle is ignored and must be re-presented next cycle
- rf_wen_o  out  1  register file write enable (drives `wb_reg_write_i` of decode)
- rf_rd_addr_o  out  5  register file write address
- rf_data_o  out  32  register file write data
- busy_o  out  32  bit k = 1 if any FIFO entry targets xk; bit 0 always 0

## Operation
- **Divider accept:**
  - Handshake `div_valid_i && div_ready_o` pushes {addr, data} at the clock edge.
  - `div_ready_o = rst_n && (count < DEPTH)`, based on the registered count; no same-cycle pop bypass.
  - A result with rd = x0 is accepted and discarded: no push, no busy bit.
- **Per-cycle grant, exactly one source:**
  - If `pipe_hold_o = 1` and the FIFO is non-empty: grant the FIFO head and pop.
  - Otherwise, if `wb_reg_write_i = 1` and `wb_rd_addr_i ≠ 0`: grant the pipeline.
  - Otherwise, if the FIFO is non-empty: grant the FIFO head and pop.
  - Otherwise: no grant.
- **Pipeline writes to x0:** dropped. They count as an idle cycle for the FIFO, so the FIFO may be granted that cycle.
- **Starvation counter (0..STARVE_MAX):**
  - Increments on each pipeline grant made while the FIFO is non-empty.
  - Clears on any FIFO grant, or when the FIFO is empty.
  - When it reaches STARVE_MAX, `pipe_hold_o` is registered high for exactly the next cycle and the counter clears.
  - `pipe_hold_o` is never high two cycles in a row.
- **Busy mask:**
  - Recomputed from valid FIFO entries after each push/pop edge.
  - Duplicate addresses in the FIFO keep the bit set until the last matching entry pops.
- **Ordering:**
  - Writes reach the port in grant order; no WAW squash is performed.
  - The hazard unit must not issue a pipeline writer to an rd that is busy or in flight in the divider.
- **Simultaneous push and pop:** both occur; count is unchanged. When the FIFO is empty, push and pop in the same cycle is impossible because there is no bypass.

## Timing
- **Reset** (`rst_n = 0` at an edge):
  - FIFO empty, pointers 0, starve counter 0.
  - `rf_wen_o = 0`, `rf_rd_addr_o = 0`, `rf_data_o = 0`, `pipe_hold_o = 0`, `busy_o = 0`.
  - `div_ready_o = 0` while `rst_n` is low.
  - Reset mid-operation discards buffered results without writing them.
- **Outputs:** `rf_*` are registered; the write is presented the cycle after its grant.
- **Pipeline latency:** request in cycle N → `rf_wen_o` in N+1.
- **Divider latency:** accepted in cycle N → earliest grant N+1 → `rf_wen_o` in N+2.
- **Busy mask:** `busy_o` reflects a push from N+1 and clears in the cycle after the pop grant, which is the same cycle the write appears on `rf_*`.
- **Hold cycle:** `pipe_hold_o` is registered, asserted in cycle H. The pipeline's WB request in H is not granted; the FIFO head's write appears in H+1.
- **FIFO full:** `div_ready_o` stays low until the cycle after a pop. The divider holds its result stable while valid and not ready.

## Test plan
- **Reset values:** hold `rst_n = 0` for 3 cycles with all inputs active → every output 0, including `div_ready_o`. Release → `div_ready_o = 1` in the first cycle.
- **Pipeline only:** WB writes x5 = 0x11 in cycle 10, no divider traffic → `rf_wen_o = 1`, addr 5, data 0x11 in cycle 11; `busy_o = 0` throughout.
- **Idle divider path:** divider pushes x7 = 0xDEAD in cycle 10, pipeline idle → `busy_o[7] = 1` in 11; `rf_*` writes x7 = 0xDEAD in 12; `busy_o[7] = 0` in 12.
- **Starvation hold:** with STARVE_MAX = 4, the FIFO holds x3 while the pipeline writes every cycle from cycle 20 → pipeline writes land in 21–24. `pipe_hold_o = 1` in cycle 24, x3 is written in cycle 25, and the pipeline's re-presented cycle-24 request lands in 26.
- **FIFO full:** with DEPTH = 2, two divider results are accepted while the pipeline writes continuously → `div_ready_o = 0`. A third result stays pending until the forced pop, then is accepted the cycle after the pop. No result is lost or duplicated.
- **x0 handling:** divider x0 result and pipeline x0 write in the same cycle → no `rf_wen_o`, no busy bit; the counter does not increment.
